hist_mem_arbiter: RTL and testbench
===================================

# hist_mem_arbiter

Parametrised arbiter that shares one training-histogram memory port among N requesters (port 0 = HCU, port 1 = DCU by default). It replaces the static select mux with a per-port req/gnt handshake and a per-port write-permission mask. A fixed-select or round-robin mode chooses the arbitration policy. A tag pipeline routes read data back to the originating port across a configurable memory read latency. It sits between the compute/consumer units and the histogram SRAM.

## Interface
- N_PORTS, 2: number of requesters (2..8)
- ADDR_W, 21: memory address width
- DATA_W, 8: memory data width
- RD_LAT, 1: cycles from mem_ren registered to mem_rdata valid (1..4)
- WR_MASK, 2'b01: bit i = 1 lets port i write; writes from other ports are dropped

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  1  0 = fixed (only port `sel` eligible), 1 = round-robin
- sel  in  SEL_W=max(1,$clog2(N_PORTS))  selected port in fixed mode
- req_ren  in  N_PORTS  per-port read request
- req_wen  in  N_PORTS  per-port write request
- req_addr  in  N_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_PORTS*DATA_W  per-port write data
- req_gnt  out  N_PORTS  one-hot; request consumed this cycle
- rsp_valid  out  N_PORTS  one-hot; read data valid for that port
- rsp_rdata  out  N_PORTS*DATA_W  read data; zero for non-responding ports
- mem_addr  out  ADDR_W  registered
- mem_ren  out  1  registered
- mem_wen  out  1  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  memory read data

## Operation
- Effective request of port i: req_ren[i] | (req_wen[i] & WR_MASK[i]). Masked write without ren = no request; no gnt.
- Fixed mode: only port `sel` eligible. sel >= N_PORTS means no grant.
- Round-robin mode: rotating pointer ptr. Grant the first eligible port at or after ptr, wrapping. On grant to port g, ptr <= (g+1) mod N_PORTS. ptr is unchanged in fixed mode and when idle.
- req_gnt is combinational from requests, mode, sel and ptr. At most one bit is set.
- Granted access is registered onto mem_* at the next edge.
  - Write has priority: if granted port has permitted wen and ren together, mem_wen=1, mem_ren=0, no response.
  - mem_addr and mem_wdata are 0 when the cycle is idle; mem_wdata is 0 on reads.
- Tag pipeline, depth RD_LAT: entry = {valid, port index}, pushed with each mem_ren.
  - At output: rsp_valid[tag]=1 and rsp_rdata slice[tag]=mem_rdata. All other slices are 0.
- mode, sel or ptr changes never redirect in-flight reads; they return to the tagged port.

## Timing
- Request at cycle t with gnt=1: mem_* driven in cycle t+1; response in cycle t+1+RD_LAT, so total read latency is 1+RD_LAT.
- Back-to-back grants are allowed every cycle. Throughput is one access per cycle.
- Requester holds req/addr/wdata until it sees gnt. Dropping req before gnt is legal.
- Reset (any time, async assert):
  - mem_ren, mem_wen, mem_addr, mem_wdata = 0.
  - ptr = 0.
  - All tag entries are invalidated, so rsp_valid = 0 and rsp_rdata = 0.
  - In-flight reads are discarded and never answered.
- Deassertion is sampled at clk. The first grant is possible in the first cycle after release.

## Structure
- Package hist_mem_pkg holds:
  - PORT_HCU=0 and PORT_DCU=1
  - MODE_FIXED=0 and MODE_RR=1
  - default ADDR_W/DATA_W
  - helper for SEL_W
- One sub-module, rr_arbiter: N-bit request vector plus pointer in, one-hot grant plus grant index out. Purely combinational. Pointer register lives in the parent.

## Test plan
- Fixed mode, sel=0, port0 write addr 0x00010 data 0xA5, then read the same address (RD_LAT=1).
  - gnt[0] each cycle; mem_wen at t+1; rsp_valid[0] with 0xA5 at t+2 of the read; rsp_rdata[1]=0.
- Fixed mode, sel=1, port1 wen=1 ren=0 (masked).
  - No gnt, mem_wen stays 0.
  - Same with ren=1: read only, rsp_valid[1] after 2 cycles.
- Round-robin, N_PORTS=3, all three ports read continuously.
  - Grants cycle 0,1,2,0,…
  - Responses arrive in the same order, each 1+RD_LAT cycles after its grant.
- RD_LAT=3: port0 read granted, then switch to fixed sel=1 the next cycle.
  - Response still lands on rsp_valid[0] at grant+4.
- Assert rst_n low with two reads in flight.
  - All outputs 0 immediately, no rsp_valid after release.
  - ptr back to 0: first RR grant goes to port 0.

Source files
------------

// File: rtl/hist_mem_pkg.sv
// hist_mem_pkg: shared constants and helpers for the histogram memory arbiter.
package hist_mem_pkg;
    localparam int PORT_HCU   = 0;
    localparam int PORT_DCU   = 1;
    localparam int DEF_ADDR_W = 21;
    localparam int DEF_DATA_W = 8;
    typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_e;
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hist_mem_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter
    import hist_mem_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = sel_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          vld_o
);
    int j;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!vld_o && req_i[j[PW-1:0]]) begin
                vld_o              = 1'b1;
                gnt_o[j[PW-1:0]]   = 1'b1;
                idx_o              = j[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/hist_mem_arbiter.sv
// hist_mem_arbiter: shares one histogram SRAM port among N requesters with
// fixed/round-robin arbitration, write masking and tagged read-data return.
module hist_mem_arbiter
    import hist_mem_pkg::*;
#(
    parameter int                 N_PORTS = 2,
    parameter int                 ADDR_W  = DEF_ADDR_W,
    parameter int                 DATA_W  = DEF_DATA_W,
    parameter int                 RD_LAT  = 1,
    parameter logic [N_PORTS-1:0] WR_MASK = N_PORTS'(2'b01),
    localparam int                SEL_W   = sel_w(N_PORTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mode,
    input  logic [SEL_W-1:0]           sel,
    input  logic [N_PORTS-1:0]         req_ren,
    input  logic [N_PORTS-1:0]         req_wen,
    input  logic [N_PORTS*ADDR_W-1:0]  req_addr,
    input  logic [N_PORTS*DATA_W-1:0]  req_wdata,
    output logic [N_PORTS-1:0]         req_gnt,
    output logic [N_PORTS-1:0]         rsp_valid,
    output logic [N_PORTS*DATA_W-1:0]  rsp_rdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_ren,
    output logic                       mem_wen,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);
    logic [N_PORTS-1:0] eff, rr_gnt;
    logic [SEL_W-1:0]   rr_idx, g, ptr_q, ptr_d, port_q;
    logic               rr_vld, gv, wp, is_rr;
    logic               mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [RD_LAT-1:0]  tv_q;
    logic [SEL_W-1:0]   tp_q [RD_LAT];

    assign eff   = req_ren | (req_wen & WR_MASK);
    assign is_rr = (mode == MODE_RR);

    rr_arbiter #(.N(N_PORTS), .PW(SEL_W)) u_rr (
        .req_i(eff),
        .ptr_i(ptr_q),
        .gnt_o(rr_gnt),
        .idx_o(rr_idx),
        .vld_o(rr_vld)
    );

    // Write wins when the granted port asks for both; reads then get no response.
    always_comb begin
        g           = is_rr ? rr_idx : sel;
        gv          = is_rr ? rr_vld : ((int'(sel) < N_PORTS) && eff[sel]);
        req_gnt     = is_rr ? rr_gnt : (gv ? (N_PORTS'(1) << sel) : '0);
        wp          = gv && req_wen[g] && WR_MASK[g];
        mem_wen_d   = wp;
        mem_ren_d   = gv && req_ren[g] && !wp;
        mem_addr_d  = gv ? req_addr[int'(g)*ADDR_W +: ADDR_W] : '0;
        mem_wdata_d = wp ? req_wdata[int'(g)*DATA_W +: DATA_W] : '0;
        ptr_d       = (is_rr && rr_vld) ? ((int'(rr_idx) == N_PORTS-1) ? '0 : rr_idx + 1'b1) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            port_q      <= '0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tv_q        <= '0;
            for (int k = 0; k < RD_LAT; k++) tp_q[k] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            port_q      <= g;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tv_q[0]     <= mem_ren_q;
            tp_q[0]     <= port_q;
            for (int k = 1; k < RD_LAT; k++) begin
                tv_q[k] <= tv_q[k-1];
                tp_q[k] <= tp_q[k-1];
            end
        end
    end

    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // The tag travelling with each read, not the live grant, picks the return port.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (tv_q[RD_LAT-1]) begin
            rsp_valid[tp_q[RD_LAT-1]]                        = 1'b1;
            rsp_rdata[int'(tp_q[RD_LAT-1])*DATA_W +: DATA_W] = mem_rdata;
        end
    end
endmodule

// File: tb/tb_hist_mem_arbiter.sv
// tb_hist_mem_arbiter: directed + random stimulus against a sequential reference model.
module tb_hist_mem_arbiter;
    import hist_mem_pkg::*;
    localparam int N = 3, AW = 21, DW = 8, RL = 3;
    localparam logic [N-1:0] MASK = 3'b101;

    logic clk = 1'b0, rst_n = 1'b1, mode = 1'b0;
    logic [1:0] sel = '0;
    logic [N-1:0] ren = '0, wen = '0, req_gnt, rsp_valid;
    logic [AW-1:0] a [N] = '{default: '0};
    logic [DW-1:0] wd [N] = '{default: '0};
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata, rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic mem_ren, mem_wen;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a[i];
            req_wdata[i*DW +: DW] = wd[i];
        end
    end

    hist_mem_arbiter #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .WR_MASK(MASK)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .req_ren(ren), .req_wen(wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // SRAM with RL-cycle read pipeline; returns junk when no read is due.
    logic [DW-1:0] sram [16] = '{default: '0};
    logic [DW-1:0] pd [RL] = '{default: '0};
    logic [RL-1:0] pv = '0;
    logic [DW-1:0] junk = 8'h5A;
    always @(posedge clk) begin
        if (mem_wen) sram[mem_addr[3:0]] <= mem_wdata;
        pv    <= {pv[RL-2:0], mem_ren};
        pd[0] <= sram[mem_addr[3:0]];
        for (int k = 1; k < RL; k++) pd[k] <= pd[k-1];
        junk  <= 8'($urandom);
    end
    assign mem_rdata = pv[RL-1] ? pd[RL-1] : junk;

    // Reference model: memory contents, RR pointer, expected port outputs by cycle.
    int total = 0, bad = 0, cyc = 0, ptr = 0, last_g = -1;
    logic [DW-1:0] mm [16] = '{default: '0};
    logic e_ren = 0, e_wen = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    int rp [4096];
    logic [DW-1:0] rd [4096];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        logic [N-1:0] eff, eg, ev;
        logic [N*DW-1:0] erd;
        int g;
        #1;
        eff = ren | (wen & MASK);
        g = -1;
        if (mode == 1'b0) begin
            if (sel < N && eff[sel]) g = sel;
        end else
            for (int k = 0; k < N; k++) if (g < 0 && eff[(ptr + k) % N]) g = (ptr + k) % N;
        eg  = (g >= 0) ? (N'(1) << g) : '0;
        ev  = '0;
        erd = '0;
        if (rp[cyc] >= 0) begin
            ev[rp[cyc]] = 1'b1;
            erd[rp[cyc]*DW +: DW] = rd[cyc];
        end
        chk("gnt", req_gnt, eg);
        chk("mem_ren", mem_ren, e_ren);
        chk("mem_wen", mem_wen, e_wen);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("rsp_valid", rsp_valid, ev);
        chk("rsp_rdata", rsp_rdata, erd);
        e_ren = 0; e_wen = 0; e_addr = '0; e_wdata = '0;
        if (g >= 0) begin
            if (wen[g] && MASK[g]) begin
                mm[a[g][3:0]] = wd[g];
                e_wen = 1; e_addr = a[g]; e_wdata = wd[g];
            end else begin
                e_ren = 1; e_addr = a[g];
                rp[cyc+1+RL] = g;
                rd[cyc+1+RL] = mm[a[g][3:0]];
            end
            if (mode) ptr = (g + 1) % N;
        end
        last_g = g;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        ren = '0; wen = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ptr = 0; e_ren = 0; e_wen = 0; e_addr = '0; e_wdata = '0;
        for (int i = cyc; i < cyc + RL + 4; i++) rp[i] = -1;
        cyc++;
    endtask

    initial begin
        int k;
        foreach (rp[i]) rp[i] = -1;
        @(negedge clk);
        do_reset();
        // fixed sel=0: write 0x10 <= A5, then read it back
        mode = 1'b0; sel = 2'd0;
        wen[0] = 1; a[0] = 21'h10; wd[0] = 8'hA5; step();
        wen[0] = 0; ren[0] = 1; step();
        ren[0] = 0; repeat (5) step();
        // fixed sel=1: masked write alone is no request; with ren it becomes a read
        sel = 2'd1; wen[1] = 1; a[1] = 21'h10; wd[1] = 8'h3C; repeat (2) step();
        ren[1] = 1; step();
        ren[1] = 0; wen[1] = 0; repeat (5) step();
        // sel beyond N_PORTS: nobody granted
        sel = 2'd3; ren = '1; repeat (2) step();
        ren = '0;
        // round-robin with all ports reading continuously
        mode = 1'b1; ren = '1;
        for (int i = 0; i < N; i++) a[i] = AW'(i + 4);
        repeat (9) step();
        ren = '0; repeat (5) step();
        // port0 read in flight while switching to fixed sel=1
        ren[0] = 1; step();
        ren[0] = 0; mode = 1'b0; sel = 2'd1; ren[1] = 1; step();
        ren = '0; repeat (6) step();
        // reset with two reads in flight, then first RR grant goes to port 0
        mode = 1'b1; ren = '1; repeat (2) step();
        do_reset();
        repeat (RL + 2) step();
        mode = 1'b1; ren = '1; step();
        ren = '0; repeat (6) step();
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (n % 25 == 0) mode = 1'($urandom);
            sel = 2'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!ren[i] && !wen[i] && ($urandom % 2 == 1)) begin
                    k = $urandom % 3;
                    ren[i] = (k != 1);
                    wen[i] = (k != 0);
                    a[i]   = AW'($urandom % 16);
                    wd[i]  = 8'($urandom);
                end else if ($urandom % 16 == 0) begin
                    ren[i] = 0; wen[i] = 0;
                end
            end
            if (n == 200) do_reset();
            step();
            if (last_g >= 0) begin
                ren[last_g] = 0; wen[last_g] = 0;
            end
        end
        ren = '0; wen = '0; repeat (6) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
